// File: rtl/stream_mux_2to1_rr.sv
// Two-to-one stream merge with packet-granular round-robin arbitration
// and a single registered output stage (one beat of buffering).
module stream_mux_2to1_rr #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_sel,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             lastGrant_q, lastGrant_d;
    logic             outValid_q, outValid_d;
    logic [WIDTH-1:0] outData_q, outData_d;
    logic             outLast_q, outLast_d;
    logic             outSel_q, outSel_d;

    logic load;
    logic grantOne;
    logic acc0;
    logic acc1;

    // The register can take a new beat when empty or when it drains this cycle.
    assign load = ~outValid_q | out_ready;
    assign acc0 = in0_valid & in0_ready;
    assign acc1 = in1_valid & in1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lastGrant_q <= 1'b1;
            outValid_q  <= 1'b0;
            outData_q   <= '0;
            outLast_q   <= 1'b0;
            outSel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            outValid_q  <= outValid_d;
            outData_q   <= outData_d;
            outLast_q   <= outLast_d;
            outSel_q    <= outSel_d;
        end
    end

    // Grant is decided only in IDLE; a started packet locks its channel.
    always_comb begin
        state_d     = state_q;
        lastGrant_d = lastGrant_q;
        case (state_q)
            IDLE: begin
                if (acc0) begin
                    lastGrant_d = 1'b0;
                    if (!in0_last) state_d = LOCK0;
                end else if (acc1) begin
                    lastGrant_d = 1'b1;
                    if (!in1_last) state_d = LOCK1;
                end
            end
            LOCK0:   if (acc0 && in0_last) state_d = IDLE;
            LOCK1:   if (acc1 && in1_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in0_ready = 1'b0;
        in1_ready = 1'b0;
        grantOne  = in1_valid & (~in0_valid | ~lastGrant_q);
        case (state_q)
            IDLE: begin
                in0_ready = load & in0_valid & ~grantOne;
                in1_ready = load & grantOne;
            end
            LOCK0:   in0_ready = load;
            LOCK1:   in1_ready = load;
            default: ;
        endcase
    end

    always_comb begin
        outValid_d = outValid_q;
        outData_d  = outData_q;
        outLast_d  = outLast_q;
        outSel_d   = outSel_q;
        if (load) begin
            outValid_d = acc0 | acc1;
            if (acc0) begin
                outData_d = in0_data;
                outLast_d = in0_last;
                outSel_d  = 1'b0;
            end else if (acc1) begin
                outData_d = in1_data;
                outLast_d = in1_last;
                outSel_d  = 1'b1;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_data  = outData_q;
    assign out_last  = outLast_q;
    assign out_sel   = outSel_q;

endmodule
